count_sequence_checker: RTL and testbench

Online checker that sits directly downstream of the 3-bit binary/Gray mode counter. It samples the counter's `Count` bus and the `M` mode line every cycle, and predicts the legal successor of each sample. It flags any illegal transition, keeps a saturating error tally, and reports when the counter has run cleanly long enough to be considered locked. Its outputs drive the lab board LEDs and the self-check bench.

---
 rtl/count_sequence_checker.sv | 142 ++++++++++++++
 tb/tb_count_sequence_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - online legality checker for the 3-bit binary/Gray mode counter
module count_sequence_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             M,
    input  logic [2:0]       Count,
    input  logic             ClearErr,
    output logic             Locked,
    output logic             ErrPulse,
    output logic             Error,
    output logic [ERR_W-1:0] ErrCount,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        TRACK   = 2'b01,
        LOCKED  = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic [3:0]       LOCK_MAX = LOCK_COUNT[3:0];
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t     state;
    state_t     state_next;
    logic [3:0] streak;
    logic [3:0] streak_next;
    logic [3:0] streak_inc;
    logic [2:0] prev_count;
    logic       prev_m;
    logic [2:0] expected;
    logic       stall;
    logic       legal;
    logic       illegal;
    logic       err_edge;

    // Successor is indexed by the binary value of the previous sample in both modes.
    function automatic logic [2:0] succ(input logic [2:0] c, input logic m);
        logic [2:0] n;
        n = c + 3'd1;
        return m ? (n ^ (n >> 1)) : n;
    endfunction

    always_comb begin
        expected   = succ(prev_count, prev_m);
        stall      = (Count == prev_count);
        legal      = !stall && (Count == expected);
        illegal    = !stall && !legal;
        streak_inc = (streak >= LOCK_MAX) ? streak : streak + 4'd1;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= ACQUIRE;
            streak     <= 4'd0;
            prev_count <= 3'd0;
            prev_m     <= 1'b0;
        end else begin
            state      <= state_next;
            streak     <= streak_next;
            prev_count <= Count;
            prev_m     <= M;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        err_edge    = 1'b0;
        case (state)
            ACQUIRE: begin
                state_next  = TRACK;
                streak_next = 4'd0;
            end
            TRACK: begin
                if (illegal) begin
                    state_next  = FAULT;
                    streak_next = 4'd0;
                    err_edge    = 1'b1;
                end else if (legal) begin
                    streak_next = streak_inc;
                    if (streak_inc == LOCK_MAX) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (illegal) begin
                    state_next  = FAULT;
                    streak_next = 4'd0;
                    err_edge    = 1'b1;
                end
            end
            FAULT: begin
                // Tracking resumes from the faulty sample; a second bad edge re-enters FAULT.
                if (illegal) begin
                    state_next  = FAULT;
                    streak_next = 4'd0;
                    err_edge    = 1'b1;
                end else begin
                    state_next = TRACK;
                    if (legal) begin
                        streak_next = streak_inc;
                    end
                end
            end
            default: begin
                state_next  = ACQUIRE;
                streak_next = 4'd0;
            end
        endcase
    end

    // A new error wins over a simultaneous clear and counts from zero.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Error    <= 1'b0;
            ErrCount <= '0;
        end else if (err_edge) begin
            Error    <= 1'b1;
            if (ClearErr) begin
                ErrCount <= ERR_W'(1);
            end else if (ErrCount != ERR_MAX) begin
                ErrCount <= ErrCount + ERR_W'(1);
            end
        end else if (ClearErr) begin
            Error    <= 1'b0;
            ErrCount <= '0;
        end
    end

    always_comb begin
        Locked   = (state == LOCKED);
        ErrPulse = (state == FAULT);
        State    = state;
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed self-checking bench for count_sequence_checker
module tb_count_sequence_checker;

    logic       Clk;
    logic       nReset;
    logic       M;
    logic [2:0] Count;
    logic       ClearErr;
    logic       Locked, ErrPulse, Error;
    logic [7:0] ErrCount;
    logic [1:0] State;
    logic       Locked2, ErrPulse2, Error2;
    logic [1:0] ErrCount2;
    logic [1:0] State2;

    int n_checks = 0;
    int n_fail   = 0;

    count_sequence_checker #(.LOCK_COUNT(4), .ERR_W(8)) dut (
        .Clk(Clk), .nReset(nReset), .M(M), .Count(Count), .ClearErr(ClearErr),
        .Locked(Locked), .ErrPulse(ErrPulse), .Error(Error), .ErrCount(ErrCount), .State(State)
    );

    count_sequence_checker #(.LOCK_COUNT(4), .ERR_W(2)) dut2 (
        .Clk(Clk), .nReset(nReset), .M(M), .Count(Count), .ClearErr(ClearErr),
        .Locked(Locked2), .ErrPulse(ErrPulse2), .Error(Error2), .ErrCount(ErrCount2), .State(State2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic [2:0] c, input logic m, input logic clr);
        @(negedge Clk);
        Count    = c;
        M        = m;
        ClearErr = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        nReset   = 1'b0;
        Count    = 3'd0;
        M        = 1'b0;
        ClearErr = 1'b0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset   = 1'b0;
        Count    = 3'd5;
        M        = 1'b1;
        ClearErr = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({State, Locked, ErrPulse, Error, ErrCount} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got state=%b lk=%b ep=%b er=%b cnt=%0d want all 0",
                     State, Locked, ErrPulse, Error, ErrCount);
        end
        n_checks++;
        if ({State2, Locked2, ErrPulse2, Error2, ErrCount2} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_w2: got state=%b cnt=%0d want 0", State2, ErrCount2);
        end
        nReset = 1'b1;
    endtask

    task automatic test_binary();
        logic exp_lk;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(3'(i % 8), 1'b0, 1'b0);
            exp_lk = (i >= 4);
            n_checks++;
            if (Locked !== exp_lk) begin
                n_fail++;
                $display("FAIL bin_locked edge %0d: got %b want %b", i + 1, Locked, exp_lk);
            end
            n_checks++;
            if (ErrCount !== 8'd0 || ErrPulse !== 1'b0) begin
                n_fail++;
                $display("FAIL bin_noerr edge %0d: got cnt=%0d ep=%b want 0", i + 1, ErrCount, ErrPulse);
            end
            if (i == 0) begin
                n_checks++;
                if (State !== 2'b01) begin
                    n_fail++;
                    $display("FAIL bin_acquire_state: got %b want 01", State);
                end
            end
        end
    endtask

    task automatic test_gray();
        logic [2:0] seq [9];
        logic exp_lk;
        seq = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b100, 3'b111, 3'b000, 3'b001, 3'b011};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(seq[i], 1'b1, 1'b0);
            exp_lk = (i >= 4);
            n_checks++;
            if (Locked !== exp_lk) begin
                n_fail++;
                $display("FAIL gray_locked edge %0d: got %b want %b", i + 1, Locked, exp_lk);
            end
            n_checks++;
            if (Error !== 1'b0 || ErrCount !== 8'd0) begin
                n_fail++;
                $display("FAIL gray_noerr edge %0d: got er=%b cnt=%0d want 0", i + 1, Error, ErrCount);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [2:0] cs [4];
        logic       ms [4];
        cs = '{3'b001, 3'b011, 3'b100, 3'b101};
        ms = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(cs[i], ms[i], 1'b0);
            n_checks++;
            if (ErrPulse !== 1'b0 || Error !== 1'b0) begin
                n_fail++;
                $display("FAIL mode_noerr edge %0d: got ep=%b er=%b want 0", i + 1, ErrPulse, Error);
            end
        end
        n_checks++;
        if (State !== 2'b01) begin
            n_fail++;
            $display("FAIL mode_state: got %b want 01", State);
        end
    endtask

    task automatic test_illegal_jump();
        logic [2:0] run [5];
        logic [2:0] rec [4];
        run = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        rec = '{3'd7, 3'd0, 3'd1, 3'd2};
        do_reset();
        foreach (run[i]) step(run[i], 1'b0, (i == 4));
        n_checks++;
        if (Locked !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_prelock: got %b want 1", Locked);
        end
        step(3'd6, 1'b0, 1'b0);
        n_checks++;
        if ({ErrPulse, Error, Locked, State} !== 5'b11011 || ErrCount !== 8'd1) begin
            n_fail++;
            $display("FAIL jump_detect: got ep=%b er=%b lk=%b st=%b cnt=%0d want 1 1 0 11 1",
                     ErrPulse, Error, Locked, State, ErrCount);
        end
        for (int i = 0; i < 4; i++) begin
            step(rec[i], 1'b0, 1'b0);
            n_checks++;
            if (ErrPulse !== 1'b0) begin
                n_fail++;
                $display("FAIL jump_pulse_width edge %0d: got %b want 0", i + 1, ErrPulse);
            end
            n_checks++;
            if (Locked !== (i == 3)) begin
                n_fail++;
                $display("FAIL jump_relock edge %0d: got %b want %b", i + 1, Locked, (i == 3));
            end
        end
        n_checks++;
        if (Error !== 1'b1 || ErrCount !== 8'd1) begin
            n_fail++;
            $display("FAIL jump_sticky: got er=%b cnt=%0d want 1 1", Error, ErrCount);
        end
    endtask

    task automatic test_stall_saturation();
        logic [2:0] seq [10];
        seq = '{3'd5, 3'd6, 3'd1, 3'd2, 3'd7, 3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(3'd0, 1'b0, 1'b0);
            n_checks++;
            if (State !== 2'b01 || Error !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got st=%b er=%b want 01 0", i + 1, State, Error);
            end
        end
        foreach (seq[i]) step(seq[i], 1'b0, 1'b0);
        n_checks++;
        if (ErrCount2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_w2: got %0d want 3", ErrCount2);
        end
        n_checks++;
        if (ErrCount !== 8'd5 || Error !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_w8: got cnt=%0d er=%b want 5 1", ErrCount, Error);
        end
        step(3'd3, 1'b0, 1'b1);
        n_checks++;
        if (ErrCount !== 8'd0 || Error !== 1'b0 || ErrCount2 !== 2'd0 || Error2 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: got cnt=%0d er=%b cnt2=%0d er2=%b want 0", ErrCount, Error, ErrCount2, Error2);
        end
        n_checks++;
        if (State !== 2'b01) begin
            n_fail++;
            $display("FAIL clear_state: got %b want 01", State);
        end
        step(3'd6, 1'b0, 1'b1);
        n_checks++;
        if (Error !== 1'b1 || ErrCount !== 8'd1 || ErrPulse !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_error: got er=%b cnt=%0d ep=%b want 1 1 1", Error, ErrCount, ErrPulse);
        end
        ClearErr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [2:0] run [5];
        run = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        do_reset();
        foreach (run[i]) step(run[i], 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b0);
        n_checks++;
        if (Error !== 1'b1 || State !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_pre: got er=%b st=%b want 1 11", Error, State);
        end
        #2;
        nReset = 1'b0;
        #1;
        n_checks++;
        if ({State, Locked, ErrPulse, Error, ErrCount} !== 13'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got st=%b lk=%b ep=%b er=%b cnt=%0d want all 0",
                     State, Locked, ErrPulse, Error, ErrCount);
        end
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        step(3'd5, 1'b1, 1'b0);
        n_checks++;
        if (State !== 2'b01 || Error !== 1'b0 || ErrPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_first_sample: got st=%b er=%b ep=%b want 01 0 0", State, Error, ErrPulse);
        end
        step(3'd6, 1'b0, 1'b0);
        n_checks++;
        if (Error !== 1'b1 || ErrCount !== 8'd1) begin
            n_fail++;
            $display("FAIL areset_check_resumes: got er=%b cnt=%0d want 1 1", Error, ErrCount);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_mode_switch();
        test_illegal_jump();
        test_stall_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
